i2c_line_driver: RTL and testbench
==================================

I2C_LINE_DRIVER -- requirements
Module: i2c_line_driver

Interface
REQ-001 The block SHALL have parameter QUARTER, default 4, meaning fastClock cycles per quarter bit-period (legal range 2..1023).
REQ-002 The block SHALL have port fastClock, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of fastClock.
REQ-004 The block SHALL have port cmdValid, input, 1, meaning a command is offered.
REQ-005 The block SHALL have port cmd, input, 2, encoded as 0=START, 1=STOP, 2=WRITE_BIT, 3=READ_BIT.
REQ-006 The block SHALL have port txBit, input, 1, the bit sent by WRITE_BIT, captured at acceptance.
REQ-007 The block SHALL have port cmdReady, output, 1, meaning idle and able to accept a command.
REQ-008 The block SHALL have port sclIn, input, 1, the synchronized and debounced SCL line level.
REQ-009 The block SHALL have port sdaIn, input, 1, the synchronized and debounced SDA line level.
REQ-010 The block SHALL have port sclDriveLow, output, 1, where 1 pulls SCL low and 0 releases it (open-drain).
REQ-011 The block SHALL have port sdaDriveLow, output, 1, where 1 pulls SDA low and 0 releases it (open-drain).
REQ-012 The block SHALL have port cmdDone, output, 1, a one-cycle pulse when any command completes.
REQ-013 The block SHALL have port rxBit, output, 1, the bit sampled by READ_BIT, valid when cmdDone pulses for a READ_BIT.
REQ-014 The block SHALL have port arbLost, output, 1, a sticky flag set on arbitration loss.

Function
REQ-015 A command SHALL be accepted on a rising edge where cmdValid=1 and cmdReady=1; cmdReady SHALL be 0 from the next cycle until command completion.
REQ-016 Each command SHALL execute four phases A, B, C, D, each lasting QUARTER cycles; a quarter counter runs 0..QUARTER-1 and the phase advances on terminal count.
REQ-017 START drive values per phase SHALL be: A: SCL released, SDA released; B: SDA low; C: SDA low; D: SCL low, SDA low.
REQ-018 STOP drive values per phase SHALL be: A: SCL low, SDA low; B: SCL released, SDA low; C and D: SCL released, SDA released.
REQ-019 WRITE_BIT drive values SHALL be: A: SCL low, SDA low iff txBit=0; B and C: SCL released with SDA unchanged; D: SCL low with SDA unchanged.
REQ-020 READ_BIT SHALL use the WRITE_BIT sequence with SDA released in all phases, and SHALL load sdaIn into rxBit on the last cycle of phase C.
REQ-021 Clock stretching: in phases B and C of WRITE_BIT and READ_BIT, and in phase B of STOP, the quarter counter SHALL hold while sclDriveLow=0 and sclIn=0; the phase length therefore grows by the stretch cycles.
REQ-022 Arbitration: in WRITE_BIT with txBit=1, if sdaIn=0 on the last cycle of phase C, arbLost SHALL set and the block SHALL release SDA for the rest of the command.
REQ-023 arbLost SHALL clear only on acceptance of a START or on reset.
REQ-024 cmdDone SHALL pulse on the last cycle of phase D, and cmdReady SHALL be 1 on the following cycle; unstretched latency from acceptance to cmdDone is 4*QUARTER cycles.
REQ-025 After a command completes, the block SHALL hold sclDriveLow and sdaDriveLow at their phase-D values while idle.
REQ-026 cmdValid SHALL be ignored while cmdReady=0; no command queuing SHALL occur.
REQ-027 rxBit SHALL hold its value until the next READ_BIT sample point.

Reset
REQ-028 While reset=1, the block SHALL set cmdReady=1, sclDriveLow=0, sdaDriveLow=0, cmdDone=0, rxBit=0, arbLost=0, and clear the phase and quarter counters.
REQ-029 Reset asserted mid-command SHALL abort the command on the next edge with no cmdDone, and SHALL take precedence over a simultaneous cmdValid.

Verification
REQ-030 With QUARTER=4, issue START -> sdaDriveLow rises 4 cycles after acceptance, sclDriveLow rises 12 cycles after acceptance, and cmdDone pulses 16 cycles after acceptance.
REQ-031 With QUARTER=4, send WRITE_BIT with txBit=0 while sclIn follows sclDriveLow -> SDA is held low through phases A-D, SCL is released for 8 cycles, and cmdDone pulses at cycle 16.
REQ-032 READ_BIT with the model driving sdaIn=1 during phase C -> rxBit=1 when cmdDone pulses; repeat with sdaIn=0 -> rxBit=0.
REQ-033 WRITE_BIT while sclIn is forced to 0 for 10 cycles at the start of phase B -> cmdDone is delayed to cycle 26.
REQ-034 WRITE_BIT with txBit=1 and sdaIn=0 in phase C -> arbLost=1 and stays 1 across a following STOP; a following START clears it.
REQ-035 Assert reset during phase C of READ_BIT -> next cycle both drive outputs are 0, cmdReady=1, and no cmdDone occurs.

Source files
------------

// File: rtl/i2c_line_driver.sv
// i2c_line_driver: bit-level I2C master line sequencer.
//
// Executes one bus command at a time (START, STOP, WRITE_BIT, READ_BIT) as
// four equal phases A..D of QUARTER fastClock cycles each, driving SCL/SDA
// through open-drain "drive low" controls. Supports clock stretching by a
// slave and detects arbitration loss on written ones.
//
// Ports:
//   fastClock   - single clock for all logic
//   reset       - synchronous active-high reset
//   cmdValid    - command offered (ignored while cmdReady=0)
//   cmd[1:0]    - 0=START, 1=STOP, 2=WRITE_BIT, 3=READ_BIT
//   txBit       - bit to send for WRITE_BIT, captured at acceptance
//   cmdReady    - idle and able to accept a command
//   sclIn/sdaIn - synchronized, debounced line levels
//   sclDriveLow - 1 pulls SCL low, 0 releases it
//   sdaDriveLow - 1 pulls SDA low, 0 releases it
//   cmdDone     - one-cycle pulse when a command completes
//   rxBit       - bit sampled by the most recent READ_BIT
//   arbLost     - sticky arbitration-loss flag, cleared by START or reset
module i2c_line_driver #(
  parameter int unsigned QUARTER = 4
) (
  input  logic       fastClock,
  input  logic       reset,
  input  logic       cmdValid,
  input  logic [1:0] cmd,
  input  logic       txBit,
  output logic       cmdReady,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sclDriveLow,
  output logic       sdaDriveLow,
  output logic       cmdDone,
  output logic       rxBit,
  output logic       arbLost
);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam logic [9:0] TERM_CNT = 10'(QUARTER - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A    = 3'd1,
    ST_B    = 3'd2,
    ST_C    = 3'd3,
    ST_D    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       rx_q, rx_d;
  logic       arb_q, arb_d;
  logic       scl_low_q, scl_low_d;
  logic       sda_low_q, sda_low_d;

  logic       stretch_phase_s;
  logic       stretch_s;
  logic       terminal_s;

  // Line drive pattern {sclLow, sdaLow} for a command in a given phase.
  // A written one leaves SDA released, so after an arbitration loss the
  // line is already released for the remainder of the command.
  function automatic logic [1:0] drive_f(input logic [1:0] c,
                                         input state_t    st,
                                         input logic      tx);
    logic [1:0] d;
    d = 2'b00;
    case (c)
      CMD_START: begin
        case (st)
          ST_A:       d = 2'b00;
          ST_B, ST_C: d = 2'b01;
          ST_D:       d = 2'b11;
          default:    d = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (st)
          ST_A:    d = 2'b11;
          ST_B:    d = 2'b01;
          default: d = 2'b00;
        endcase
      end
      CMD_WRITE: begin
        case (st)
          ST_A, ST_D: d = {1'b1, ~tx};
          ST_B, ST_C: d = {1'b0, ~tx};
          default:    d = 2'b00;
        endcase
      end
      CMD_READ: begin
        case (st)
          ST_A, ST_D: d = 2'b10;
          default:    d = 2'b00;
        endcase
      end
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // Phases in which a slave holding SCL low freezes the quarter counter.
  always_comb begin
    stretch_phase_s = 1'b0;
    case (state_q)
      ST_B:    stretch_phase_s = (cmd_q != CMD_START);
      ST_C:    stretch_phase_s = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
      default: stretch_phase_s = 1'b0;
    endcase
    // Only a genuine stretch counts: we released SCL but the line is low.
    stretch_s  = stretch_phase_s & ~scl_low_q & ~sclIn;
    terminal_s = (cnt_q == TERM_CNT);
  end

  // Next-state, counter, sampling and line-drive logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    rx_d      = rx_q;
    arb_d     = arb_q;
    scl_low_d = scl_low_q;
    sda_low_d = sda_low_q;

    case (state_q)
      ST_IDLE: begin
        if (cmdValid) begin
          state_d = ST_A;
          cnt_d   = 10'd0;
          cmd_d   = cmd;
          tx_d    = txBit;
          ready_d = 1'b0;
          if (cmd == CMD_START) begin
            arb_d = 1'b0;
          end else begin
            arb_d = arb_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_A, ST_B, ST_C, ST_D: begin
        if (stretch_s) begin
          cnt_d = cnt_q;
        end else if (!terminal_s) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          cnt_d = 10'd0;
          case (state_q)
            ST_A: state_d = ST_B;
            ST_B: state_d = ST_C;
            ST_C: begin
              state_d = ST_D;
              // Last cycle of phase C is the data sample point.
              if (cmd_q == CMD_READ) begin
                rx_d = sdaIn;
              end else if ((cmd_q == CMD_WRITE) && tx_q && !sdaIn) begin
                arb_d = 1'b1;
              end else begin
                rx_d = rx_q;
              end
            end
            ST_D: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // While idle the lines keep their phase-D levels.
    if (state_d != ST_IDLE) begin
      {scl_low_d, sda_low_d} = drive_f(cmd_d, state_d, tx_d);
    end else begin
      scl_low_d = scl_low_q;
      sda_low_d = sda_low_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge fastClock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 10'd0;
      cmd_q     <= 2'd0;
      tx_q      <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      rx_q      <= 1'b0;
      arb_q     <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      rx_q      <= rx_d;
      arb_q     <= arb_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign cmdReady    = ready_q;
  assign cmdDone     = done_q;
  assign rxBit       = rx_q;
  assign arbLost     = arb_q;
  assign sclDriveLow = scl_low_q;
  assign sdaDriveLow = sda_low_q;

endmodule

// File: tb/tb_i2c_line_driver.sv
// Self-checking bench for i2c_line_driver (QUARTER=4). A progress-count
// model predicts every output each cycle; directed commands additionally
// check hand-computed latencies and flag values.
module tb_i2c_line_driver;

  localparam int Q = 4;

  logic       fastClock;
  logic       reset;
  logic       cmdValid;
  logic [1:0] cmd;
  logic       txBit;
  logic       cmdReady;
  logic       sclDriveLow;
  logic       sdaDriveLow;
  logic       cmdDone;
  logic       rxBit;
  logic       arbLost;
  logic       scl_hold;
  logic       sda_ext;
  wire        sclIn = ~sclDriveLow & ~scl_hold;
  wire        sdaIn = ~sdaDriveLow & sda_ext;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  i2c_line_driver #(.QUARTER(Q)) dut (
    .fastClock  (fastClock),
    .reset      (reset),
    .cmdValid   (cmdValid),
    .cmd        (cmd),
    .txBit      (txBit),
    .cmdReady   (cmdReady),
    .sclIn      (sclIn),
    .sdaIn      (sdaIn),
    .sclDriveLow(sclDriveLow),
    .sdaDriveLow(sdaDriveLow),
    .cmdDone    (cmdDone),
    .rxBit      (rxBit),
    .arbLost    (arbLost)
  );

  initial fastClock = 1'b0;
  always #5 fastClock = ~fastClock;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid = 1'b0;
  logic       m_busy, m_tx, m_scl, m_sda, m_ready, m_done, m_rx, m_arb;
  logic [1:0] m_cmd;
  int         m_p;

  // SCL pulled low?  START: phase D; STOP: phase A; data bits: A and D.
  function automatic logic exp_scl(input logic [1:0] c, input int ph);
    if (c == 2'd0) return ph == 3;
    if (c == 2'd1) return ph == 0;
    return (ph == 0) || (ph == 3);
  endfunction

  // SDA pulled low?  START: after A; STOP: A and B; WRITE: txBit==0; READ: never.
  function automatic logic exp_sda(input logic [1:0] c, input int ph, input logic tx);
    if (c == 2'd0) return ph != 0;
    if (c == 2'd1) return ph <= 1;
    if (c == 2'd2) return !tx;
    return 1'b0;
  endfunction

  task automatic model_step();
    int  ph;
    logic stall;
    if (reset) begin
      m_valid = 1'b1; m_busy = 1'b0; m_p = 0; m_ready = 1'b1; m_done = 1'b0;
      m_scl = 1'b0; m_sda = 1'b0; m_rx = 1'b0; m_arb = 1'b0; m_cmd = 2'd0; m_tx = 1'b0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (cmdValid) begin
          m_busy = 1'b1; m_cmd = cmd; m_tx = txBit; m_p = 0; m_ready = 1'b0;
          if (cmd == 2'd0) m_arb = 1'b0;
          m_scl = exp_scl(m_cmd, 0);
          m_sda = exp_sda(m_cmd, 0, m_tx);
        end
      end else begin
        ph = m_p / Q;
        stall = !m_scl && !sclIn &&
                (((ph == 1 || ph == 2) && m_cmd >= 2'd2) || (ph == 1 && m_cmd == 2'd1));
        if (!stall) begin
          if (m_p == 3 * Q - 1) begin
            if (m_cmd == 2'd3) m_rx = sdaIn;
            if (m_cmd == 2'd2 && m_tx && !sdaIn) m_arb = 1'b1;
          end
          m_p = m_p + 1;
          if (m_p == 4 * Q) begin
            m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
          end else begin
            m_scl = exp_scl(m_cmd, m_p / Q);
            m_sda = exp_sda(m_cmd, m_p / Q, m_tx);
          end
        end
      end
    end
  endtask

  // Model update on each edge, then cycle-by-cycle comparison just after it.
  initial begin
    forever begin
      @(posedge fastClock);
      cyc = cyc + 1;
      model_step();
      #1;
      if (m_valid) begin
        check("cmdReady",    int'(cmdReady),    int'(m_ready));
        check("sclDriveLow", int'(sclDriveLow), int'(m_scl));
        check("sdaDriveLow", int'(sdaDriveLow), int'(m_sda));
        check("cmdDone",     int'(cmdDone),     int'(m_done));
        check("rxBit",       int'(rxBit),       int'(m_rx));
        check("arbLost",     int'(arbLost),     int'(m_arb));
      end
    end
  end

  // ---------------- directed command driver ----------------
  // k = cycles since the acceptance edge. Stimulus windows are in k.
  task automatic run_cmd(input logic [1:0] c, input logic t, input int hold_valid,
                         input int st_from, input int st_len,
                         input int sl_from, input int sl_to, input int rst_at,
                         output int done_k, output int sda_k, output int scl_k,
                         output int rel_n, output int sdalow_n,
                         output logic rx_at_done, output logic [3:0] rst_snap);
    int   acc;
    int   k;
    logic prev_sda, prev_scl;
    done_k = -1; sda_k = -1; scl_k = -1; rel_n = 0; sdalow_n = 0;
    rx_at_done = 1'b0; rst_snap = 4'b0000;
    for (int n = 0; n < 50 && !cmdReady; n++) @(negedge fastClock);
    check("ready_before_cmd", int'(cmdReady), 1);
    cmdValid = 1'b1; cmd = c; txBit = t;
    acc = cyc + 1;
    prev_sda = sdaDriveLow; prev_scl = sclDriveLow;
    for (int i = 0; i < 100; i++) begin
      @(negedge fastClock);
      k = cyc - acc;
      if (k >= 1 && done_k < 0) begin
        if (!sclDriveLow) rel_n++;
        if (sdaDriveLow) sdalow_n++;
      end
      if (sdaDriveLow && !prev_sda && sda_k < 0) sda_k = k;
      if (sclDriveLow && !prev_scl && scl_k < 0) scl_k = k;
      prev_sda = sdaDriveLow; prev_scl = sclDriveLow;
      if (cmdDone && done_k < 0) begin
        done_k = k; rx_at_done = rxBit;
      end
      if (k == 0) begin
        if (hold_valid > 0) cmd = 2'd0;
        else cmdValid = 1'b0;
      end
      if (k == hold_valid) cmdValid = 1'b0;
      if (k == st_from) scl_hold = 1'b1;
      if (k == st_from + st_len) scl_hold = 1'b0;
      if (k == sl_from) sda_ext = 1'b0;
      if (k == sl_to) sda_ext = 1'b1;
      if (rst_at >= 0 && k == rst_at) reset = 1'b1;
      if (rst_at >= 0 && k == rst_at + 1) begin
        rst_snap = {sclDriveLow, sdaDriveLow, cmdReady, cmdDone};
        reset = 1'b0;
      end
      if (done_k >= 0) break;
      if (rst_at >= 0 && k == rst_at + 6) break;
    end
    cmdValid = 1'b0; scl_hold = 1'b0; sda_ext = 1'b1;
  endtask

  int         d_k, s_k, c_k, rel, sdl;
  logic       rxd;
  logic [3:0] snap;

  initial begin
    reset = 1'b1; cmdValid = 1'b0; cmd = 2'd0; txBit = 1'b0;
    scl_hold = 1'b0; sda_ext = 1'b1;
    repeat (3) @(negedge fastClock);
    check("rst_ready", int'(cmdReady), 1);
    check("rst_scl",   int'(sclDriveLow), 0);
    check("rst_sda",   int'(sdaDriveLow), 0);
    check("rst_done",  int'(cmdDone), 0);
    check("rst_rx",    int'(rxBit), 0);
    check("rst_arb",   int'(arbLost), 0);
    reset = 1'b0;
    @(negedge fastClock);

    // START: SDA falls at 4, SCL falls at 12, done at 16.
    run_cmd(2'd0, 1'b0, 0, -1, 0, -1, -1, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("start_sda_rise", s_k, 4);
    check("start_scl_rise", c_k, 12);
    check("start_done",     d_k, 16);

    // WRITE 0 with cmdValid held (and changed) while busy: must be ignored.
    run_cmd(2'd2, 1'b0, 4, -1, 0, -1, -1, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("wr0_done",      d_k, 16);
    check("wr0_scl_rel",   rel, 8);
    check("wr0_sda_low",   sdl, 16);
    check("wr0_still_ok",  int'(arbLost), 0);

    // READ with SDA high then low during phase C.
    run_cmd(2'd3, 1'b0, 0, -1, 0, -1, -1, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("rd1_done", d_k, 16);
    check("rd1_rx",   int'(rxd), 1);
    run_cmd(2'd3, 1'b0, 0, -1, 0, 8, 12, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("rd0_done", d_k, 16);
    check("rd0_rx",   int'(rxd), 0);

    // WRITE 1 with a 10-cycle stretch at the start of phase B.
    run_cmd(2'd2, 1'b1, 0, 4, 10, -1, -1, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("stretch_done", d_k, 26);
    check("stretch_arb",  int'(arbLost), 0);

    // WRITE 1 with SDA low in phase C: arbitration lost.
    run_cmd(2'd2, 1'b1, 0, -1, 0, 8, 12, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("arb_done", d_k, 16);
    check("arb_set",  int'(arbLost), 1);
    run_cmd(2'd1, 1'b0, 0, -1, 0, -1, -1, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("stop_done",    d_k, 16);
    check("arb_after_stop", int'(arbLost), 1);
    run_cmd(2'd0, 1'b0, 0, -1, 0, -1, -1, -1, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("arb_after_start", int'(arbLost), 0);

    // Reset during phase C of READ_BIT: abort, no cmdDone.
    run_cmd(2'd3, 1'b0, 0, -1, 0, -1, -1, 10, d_k, s_k, c_k, rel, sdl, rxd, snap);
    check("rstmid_snap", int'(snap), 2);
    check("rstmid_nodone", d_k, -1);

    // Reset wins over a simultaneous cmdValid.
    reset = 1'b1; cmdValid = 1'b1; cmd = 2'd2; txBit = 1'b0;
    @(negedge fastClock);
    check("rstvalid_ready", int'(cmdReady), 1);
    check("rstvalid_scl",   int'(sclDriveLow), 0);
    check("rstvalid_sda",   int'(sdaDriveLow), 0);
    reset = 1'b0; cmdValid = 1'b0;
    @(negedge fastClock);
    check("rstvalid_idle", int'(cmdReady), 1);
    repeat (2) @(negedge fastClock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
